// File: rtl/univ_shift_pkg.sv
// rtl/univ_shift_pkg.sv - op codes, FSM states and single-step datapath for the universal shift register
package univ_shift_pkg;

  // Widest register the step function can serve; callers pass their own width.
  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);

  typedef enum logic [2:0] {
    LOAD  = 3'b000,
    SHL   = 3'b001,
    SHR   = 3'b010,
    ROL   = 3'b011,
    ROR   = 3'b100,
    ASR   = 3'b101,
    CLEAR = 3'b110,
    NOP   = 3'b111
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // One single-bit step of op on the low 'width' bits of q; bits above width come back as 0.
  // LOAD and NOP leave q unchanged here since the parallel value is handled by the caller.
  function automatic logic [MAX_W-1:0] shift_step(
    input logic [MAX_W-1:0] q,
    input op_e              op,
    input logic             sin_l,
    input logic             sin_r,
    input int               width
  );
    logic [MAX_W-1:0] sl;
    logic [MAX_W-1:0] sr;
    logic [MAX_W-1:0] r;
    logic             msb;
    logic             lsb;
    sl  = q << 1;
    sr  = q >> 1;
    msb = q[IDX_W'(width - 1)];
    lsb = q[0];
    r   = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        case (op)
          SHL:     r[i] = (i == 0)         ? sin_r : sl[i];
          SHR:     r[i] = (i == width - 1) ? sin_l : sr[i];
          ROL:     r[i] = (i == 0)         ? msb   : sl[i];
          ROR:     r[i] = (i == width - 1) ? lsb   : sr[i];
          ASR:     r[i] = (i == width - 1) ? msb   : sr[i];
          CLEAR:   r[i] = 1'b0;
          default: r[i] = q[i];
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_register.sv
// rtl/univ_shift_register.sv - universal shift register with start/busy/done multi-step commands
module univ_shift_register
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nxt;
  op_e              op_q, op_nxt;
  logic [CNT_W-1:0] rem_q, rem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] q_step;

  // Serial outputs are taps straight off the register.
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  // One step of the latched op; serial inputs are taken live at each step edge.
  assign q_step = WIDTH'(shift_step(MAX_W'(q), op_q, sin_l, sin_r, WIDTH));

  // State, data and handshake registers; reset aborts any command without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= LOAD;
      rem_q <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
      rem_q <= rem_nxt;
      q     <= q_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Command acceptance in IDLE and step/countdown in SHIFT; start while busy is dropped.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    rem_nxt   = rem_q;
    q_nxt     = q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          case (op_e'(op))
            LOAD: begin
              q_nxt    = load_data;
              done_nxt = 1'b1;
            end
            CLEAR: begin
              q_nxt    = '0;
              done_nxt = 1'b1;
            end
            NOP: begin
              done_nxt = 1'b1;
            end
            default: begin
              if (count == '0) begin
                done_nxt = 1'b1;
              end else begin
                op_nxt    = op_e'(op);
                rem_nxt   = count;
                busy_nxt  = 1'b1;
                state_nxt = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        q_nxt   = q_step;
        rem_nxt = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_univ_shift_register.sv
// tb/tb_univ_shift_register.sv - scoreboard bench for univ_shift_register
module tb_univ_shift_register;
  import univ_shift_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [3:0] count;
  logic [7:0] load_data;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [3:0] count;
    logic [7:0] load_data;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } stim_t;

  stim_t sb[$];

  univ_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .count     (count),
    .load_data (load_data),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(logic r, logic s, op_e o, logic [3:0] c, logic [7:0] ld,
                               logic sl, logic sr, logic [7:0] eq, logic eb, logic ed);
    stim_t t;
    t.rst = r; t.start = s; t.op = o; t.count = c; t.load_data = ld;
    t.sin_l = sl; t.sin_r = sr; t.q = eq; t.busy = eb; t.done = ed;
    return t;
  endfunction

  function automatic void drive(stim_t t);
    rst = t.rst; start = t.start; op = t.op; count = t.count;
    load_data = t.load_data; sin_l = t.sin_l; sin_r = t.sin_r;
  endfunction

  task automatic test_reset();
    stim_t t[$];
    stim_t e;
    t.push_back(mk(1, 1, LOAD, 0, 8'hFF, 0, 0, 8'h00, 0, 0));
    t.push_back(mk(1, 1, LOAD, 0, 8'hFF, 0, 0, 8'h00, 0, 0));
    t.push_back(mk(0, 0, NOP,  0, 8'h00, 0, 0, 8'h00, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done) begin
        failures++;
        $display("FAIL test_reset step %0d: got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_load();
    stim_t t[$];
    stim_t e;
    t.push_back(mk(0, 1, LOAD, 0, 8'hA5, 0, 0, 8'hA5, 0, 1));
    t.push_back(mk(0, 0, NOP,  0, 8'h00, 0, 0, 8'hA5, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done) begin
        failures++;
        $display("FAIL test_load step %0d: got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_rol();
    stim_t t[$];
    stim_t e;
    t.push_back(mk(0, 1, ROL, 3, 8'h00, 0, 0, 8'hA5, 1, 0));
    t.push_back(mk(0, 0, NOP, 0, 8'h00, 0, 0, 8'h4B, 1, 0));
    t.push_back(mk(0, 0, NOP, 0, 8'h00, 0, 0, 8'h96, 1, 0));
    t.push_back(mk(0, 0, NOP, 0, 8'h00, 0, 0, 8'h2D, 0, 1));
    t.push_back(mk(0, 0, NOP, 0, 8'h00, 0, 0, 8'h2D, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done) begin
        failures++;
        $display("FAIL test_rol step %0d: got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_asr_shl_back_to_back();
    stim_t t[$];
    stim_t e;
    t.push_back(mk(0, 1, LOAD,  0, 8'h96, 0, 0, 8'h96, 0, 1));
    t.push_back(mk(0, 1, ASR,   2, 8'h00, 0, 0, 8'h96, 1, 0));
    t.push_back(mk(0, 0, NOP,   0, 8'h00, 0, 0, 8'hCB, 1, 0));
    t.push_back(mk(0, 1, LOAD,  0, 8'h0F, 0, 0, 8'hE5, 0, 1));
    t.push_back(mk(0, 1, LOAD,  0, 8'h0F, 0, 0, 8'h0F, 0, 1));
    t.push_back(mk(0, 1, SHL,   4, 8'h00, 0, 1, 8'h0F, 1, 0));
    t.push_back(mk(0, 1, CLEAR, 0, 8'h00, 0, 1, 8'h1F, 1, 0));
    t.push_back(mk(0, 0, NOP,   0, 8'h00, 0, 1, 8'h3F, 1, 0));
    t.push_back(mk(0, 0, NOP,   0, 8'h00, 0, 1, 8'h7F, 1, 0));
    t.push_back(mk(0, 0, NOP,   0, 8'h00, 0, 1, 8'hFF, 0, 1));
    t.push_back(mk(0, 0, NOP,   0, 8'h00, 0, 0, 8'hFF, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done) begin
        failures++;
        $display("FAIL test_asr_shl step %0d: got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_shr_serial();
    stim_t t[$];
    stim_t e;
    logic [7:0] m;
    logic       s;
    m = 8'h00;
    t.push_back(mk(0, 1, LOAD, 0, 8'h00, 0, 0, m, 0, 1));
    t.push_back(mk(0, 1, SHR,  8, 8'h00, 0, 0, m, 1, 0));
    for (int k = 1; k <= 8; k++) begin
      s = (k % 2 == 1);
      m = {s, m[7:1]};
      t.push_back(mk(0, 0, NOP, 0, 8'h00, s, 0, m, (k < 8), (k == 8)));
    end
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done ||
          sout_r !== e.q[0] || sout_l !== e.q[7]) begin
        failures++;
        $display("FAIL test_shr step %0d: got q=%h busy=%b done=%b sout_l=%b sout_r=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, sout_l, sout_r, e.q, e.busy, e.done);
      end
    end
    checks++;
    if (q !== 8'h55) begin
      failures++;
      $display("FAIL test_shr final: got q=%h want q=55", q);
    end
  endtask

  task automatic test_long_count();
    stim_t t[$];
    stim_t e;
    logic [7:0] m;
    m = 8'h81;
    t.push_back(mk(0, 1, LOAD, 0, 8'h81, 0, 0, m, 0, 1));
    t.push_back(mk(0, 1, ROL,  9, 8'h00, 0, 0, m, 1, 0));
    for (int k = 1; k <= 9; k++) begin
      m = {m[6:0], m[7]};
      t.push_back(mk(0, 0, NOP, 0, 8'h00, 0, 0, m, (k < 9), (k == 9)));
    end
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done) begin
        failures++;
        $display("FAIL test_long_count step %0d: got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, e.q, e.busy, e.done);
      end
    end
    checks++;
    if (q !== 8'h03) begin
      failures++;
      $display("FAIL test_long_count final: got q=%h want q=03", q);
    end
  endtask

  task automatic test_abort_and_zero_count();
    stim_t t[$];
    stim_t e;
    t.push_back(mk(0, 1, LOAD, 0, 8'h01, 0, 0, 8'h01, 0, 1));
    t.push_back(mk(0, 1, ROR,  5, 8'h00, 0, 0, 8'h01, 1, 0));
    t.push_back(mk(0, 0, NOP,  0, 8'h00, 0, 0, 8'h80, 1, 0));
    t.push_back(mk(0, 0, NOP,  0, 8'h00, 0, 0, 8'h40, 1, 0));
    t.push_back(mk(1, 0, NOP,  0, 8'h00, 0, 0, 8'h00, 0, 0));
    t.push_back(mk(0, 0, NOP,  0, 8'h00, 0, 0, 8'h00, 0, 0));
    t.push_back(mk(0, 0, NOP,  0, 8'h00, 0, 0, 8'h00, 0, 0));
    t.push_back(mk(0, 1, LOAD, 0, 8'h3C, 0, 0, 8'h3C, 0, 1));
    t.push_back(mk(0, 1, ROR,  0, 8'h00, 0, 0, 8'h3C, 0, 1));
    t.push_back(mk(0, 0, NOP,  0, 8'h00, 0, 0, 8'h3C, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      sb.push_back(t[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done) begin
        failures++;
        $display("FAIL test_abort step %0d: got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, q, busy, done, e.q, e.busy, e.done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; count = '0;
    load_data = '0; sin_l = 1'b0; sin_r = 1'b0;
    test_reset();
    test_load();
    test_rol();
    test_asr_shl_back_to_back();
    test_shr_serial();
    test_long_count();
    test_abort_and_zero_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
Parametrised universal shift register, successor to the single-bit bidirectional shifter. Supports parallel load, clear, logical/arithmetic shifts and rotates in either direction, plus multi-step commands. A start/busy/done handshake lets a controller request N single-bit shifts and wait for completion. Used by serial-link and bit-manipulation datapaths.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, width of the shift-count field; max steps per command = 2**CNT_W - 1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  command request; accepted only when busy=0
op  in  3  operation code, sampled with start
count  in  CNT_W  number of single-bit steps, sampled with start
load_data  in  WIDTH  parallel load value, sampled with start
sin_l  in  1  serial input entering at MSB (SHR)
sin_r  in  1  serial input entering at LSB (SHL)
q  out  WIDTH  register contents
sout_l  out  1  q[WIDTH-1], combinational from q
sout_r  out  1  q[0], combinational from q
busy  out  1  multi-step command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=1 at an edge): q=0, busy=0, done=0, remaining-count=0, latched op=LOAD, FSM->IDLE. Reset overrides start and aborts any command in progress; no done pulse is produced for the aborted command.
- Op codes: 000 LOAD, 001 SHL (q<={q[W-2:0],sin_r}), 010 SHR (q<={sin_l,q[W-1:1]}), 011 ROL, 100 ROR, 101 ASR (MSB replicated), 110 CLEAR, 111 NOP.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - LOAD: q<=load_data.
  - CLEAR: q<=0.
  - NOP: q unchanged.
  - For all three: done<=1 at E0, busy stays 0.
  - Shift/rotate with count=0: q unchanged, done<=1 at E0, busy stays 0.
  - Shift/rotate with count=N>0: latch op and N, busy<=1, ->SHIFT. q is not modified at E0.
- SHIFT: each edge E1..EN performs exactly one step of the latched op and decrements remaining-count.
  - At EN: busy<=0, done<=1, ->IDLE.
  - Latency start-to-done = N edges after E0; busy is high for exactly N cycles.
- Serial inputs are sampled at each step edge, not at start.
- op, count and load_data are ignored while busy. start while busy is ignored and is not queued.
- done is high for exactly one cycle, then returns to 0. A new start may be accepted in the cycle done is high (busy=0).
- count > WIDTH is legal: shifts keep filling, rotates wrap modulo WIDTH.
- Outputs q, busy and done are registered. sout_l and sout_r are pure wires from q.

Decomposition:
- Package univ_shift_pkg: op_e enum (8 codes above), state_e enum {IDLE, SHIFT}, and a pure function shift_step(q, op, sin_l, sin_r) returning the next q.
- No sub-module is required. Counter and FSM live in the top module; the datapath is the package function so the bench model can reuse it.

Test Plan:
(All with WIDTH=8.)
1. rst held 2 cycles with start=1, op=LOAD, load_data=0xFF -> q=0x00, busy=0, done=0 after release.
2. LOAD 0xA5 -> q=0xA5 and done=1 one edge later; busy never asserts; done=0 the following cycle.
3. ROL count=3 from 0xA5 -> busy high 3 cycles; q steps 0x4B, 0x96, 0x2D; done pulses coincident with q=0x2D.
4. ASR count=2 from 0x96 -> q=0xCB then 0xE5; then SHL count=4 from 0x0F with sin_r=1 -> q=0xFF. A start with op=CLEAR asserted mid-command is ignored and q is not cleared.
5. SHR count=8 with sin_l toggling 1,0,1,0,... starting at 1 -> q=0x55 (first-entered bit ends in q[0]); sout_r tracks q[0] each cycle.
6. ROR count=5 from 0x01, rst asserted after the 2nd step -> q=0x00, busy=0 next edge, no done; then ROR count=0 -> q unchanged, done at E0, busy stays 0.
